mac_layer_sequencer: RTL and testbench
======================================

# mac_layer_sequencer

Time-multiplexed dense-layer engine for the ECG classifier. A single multiply-accumulate unit is shared across all neurons of one layer. Weights and biases are read from an external synchronous ROM. Each neuron's result passes through the layer's clamped ReLU to 8 bits and is emitted on a valid/ready stream. The block replaces a bank of per-neuron nodes when area matters more than throughput.

## Interface
- N_IN, 10, activations per neuron (inputs to the layer)
- N_OUT, 10, neurons in the layer
- DW, 24, datapath/accumulator width (two's complement)
- AW, 8, ROM address width; must satisfy 2^AW >= N_OUT*(N_IN+1)

- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- start  in  1  request one layer evaluation; accepted only in IDLE
- act_in  in  N_IN*DW  activations, element j at bits [j*DW +: DW]; captured on accepted start
- busy  out  1  high from accepted start until done
- w_rd  out  1  ROM read strobe
- w_addr  out  AW  ROM address: o*(N_IN+1)+k, where k=N_IN selects bias of neuron o
- w_data  in  DW  ROM data, valid the cycle after w_rd
- out_valid  out  1  out_data/out_idx valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_idx  out  8  neuron index o of current output
- out_data  out  8  activated neuron output
- done  out  1  one-cycle pulse after last neuron accepted

## Operation
- States: IDLE, FETCH, EMIT, DONE.
- IDLE:
  - start=1 captures act_in into act[] and clears o, k and acc.
  - Goes to FETCH.
- FETCH, k = 0..N_IN+1:
  - While k<=N_IN: w_rd=1, w_addr=o*(N_IN+1)+k.
  - At k=N_IN+1: w_rd=0.
  - Each edge where the previous cycle had w_rd=1 with index j:
    - j<N_IN: acc <= acc + act[j]*w_data.
    - j=N_IN: acc <= acc + w_data (bias).
  - After k=N_IN+1, go to EMIT.
- Arithmetic: products and sums truncated modulo 2^DW; no overflow detection.
- Activation, registered on entry to EMIT:
  - acc[DW-1]=1 -> 0.
  - acc > 4096 -> 255.
  - Otherwise -> acc[12:5].
  - Boundary cases: acc=4096 gives 128; acc=4097 gives 255.
- EMIT:
  - Holds out_valid=1 with out_idx=o and out_data stable until out_ready=1.
  - On handshake with o<N_OUT-1: o <= o+1, acc <= 0, k <= 0, go to FETCH.
  - On handshake with o=N_OUT-1: go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored. act[] does not change mid-evaluation.

## Timing
- Reset values: busy=0, w_rd=0, w_addr=0, out_valid=0, out_idx=0, out_data=0, done=0, state=IDLE, acc=0.
- Reset asserted in any state aborts the evaluation next edge. No further ROM reads and no out_valid until a new start.
- Start edge = edge 0.
  - busy=1 from cycle after edge 0.
  - First w_rd in cycle after edge 0.
- Per neuron: N_IN+2 FETCH cycles, then at least 1 EMIT cycle.
- With out_ready tied high:
  - out_valid for neuron o is high exactly in cycle (o+1)*(N_IN+3) after edge 0.
  - Defaults: cycles 13, 26, … 130.
  - done is high in cycle N_OUT*(N_IN+3)+1 (default 131).
  - busy falls with done's deassertion.
- Backpressure: each cycle out_ready=0 in EMIT delays all later events by one cycle. No ROM reads occur during EMIT.
- start high in the same cycle as done is ignored. It is accepted the next cycle if still high.
- out_ready while out_valid=0 has no effect.

## Test plan
- Nominal output: all act=32, all weights=1, bias=0, out_ready=1 -> acc=320. Every out_data=10. out_idx 0..9 in cycles 13,26,…,130. done in cycle 131.
- Saturation and ReLU: act=1000, weights=10, bias=6 -> out_data=255. Weights=-1, bias=0 -> acc negative, out_data=0.
- Clamp boundary: acc=4096 (act[0]=4096, weight 1, rest 0) -> 128. acc=4097 -> 255. acc=4095 -> 127.
- Backpressure: out_ready=0 for 5 cycles on neuron 3 -> out_valid and out_data held stable, w_rd=0 throughout. Neuron 4 out_valid shifts by 5 cycles. done in cycle 136.
- Reset mid-run: reset=0 in cycle 40 -> next cycle all outputs at reset values. A new start yields the full correct sequence with no residue in acc.
- Protocol: start re-asserted while busy -> ignored, act[] unchanged. Addresses checked equal o*11+k across the run, never exceeding 109.

Source files
------------

// File: rtl/mac_layer_sequencer.sv
// Time-multiplexed dense layer: one shared MAC walks every neuron's weights and bias
// from a synchronous ROM and streams each clamped-ReLU result out on valid/ready.
module mac_layer_sequencer #(
  parameter int N_IN  = 10,
  parameter int N_OUT = 10,
  parameter int DW    = 24,
  parameter int AW    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_IN*DW-1:0] act_in,
  output logic               busy,
  output logic               w_rd,
  output logic [AW-1:0]      w_addr,
  input  logic [DW-1:0]      w_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_idx,
  output logic [7:0]         out_data,
  output logic               done
);

  localparam int KW = $clog2(N_IN + 2);
  localparam logic [KW-1:0] K_BIAS = KW'(N_IN);
  localparam logic [KW-1:0] K_LAST = KW'(N_IN + 1);
  localparam logic [7:0]    O_LAST = 8'(N_OUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

  state_t        state;
  logic [DW-1:0] act [N_IN];
  logic [DW-1:0] acc;
  logic [DW-1:0] acc_next;
  logic [DW-1:0] term;
  logic [KW-1:0] k;
  logic [KW-1:0] pend_idx;
  logic          pend;
  logic [7:0]    o;

  function automatic logic [7:0] relu_clamp(input logic [DW-1:0] a);
    if (a[DW-1])
      return 8'd0;
    else if (a > DW'(4096))
      return 8'hFF;
    else
      return a[12:5];
  endfunction

  // ROM data lags the read strobe by a cycle, so accumulate against the delayed index
  always_comb begin
    term = '0;
    if (pend) begin
      if (pend_idx == K_BIAS)
        term = w_data;
      else if (pend_idx < K_BIAS)
        term = act[pend_idx] * w_data;
    end
    acc_next = acc + term;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      w_rd      <= 1'b0;
      w_addr    <= '0;
      out_valid <= 1'b0;
      out_idx   <= 8'd0;
      out_data  <= 8'd0;
      done      <= 1'b0;
      acc       <= '0;
      k         <= '0;
      pend      <= 1'b0;
      pend_idx  <= '0;
      o         <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N_IN; i++)
              act[i] <= act_in[i*DW +: DW];
            o      <= 8'd0;
            k      <= '0;
            acc    <= '0;
            pend   <= 1'b0;
            busy   <= 1'b1;
            w_rd   <= 1'b1;
            w_addr <= '0;
            state  <= FETCH;
          end
        end
        FETCH: begin
          acc      <= acc_next;
          pend     <= w_rd;
          pend_idx <= k;
          if (k < K_BIAS) begin
            k      <= k + 1'b1;
            w_addr <= w_addr + 1'b1;
          end else if (k == K_BIAS) begin
            k    <= K_LAST;
            w_rd <= 1'b0;
          end else begin
            // The bias lands this edge, so the activation sees the final sum
            state     <= EMIT;
            out_valid <= 1'b1;
            out_idx   <= o;
            out_data  <= relu_clamp(acc_next);
            pend      <= 1'b0;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (o == O_LAST) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              o      <= o + 1'b1;
              k      <= '0;
              acc    <= '0;
              w_rd   <= 1'b1;
              w_addr <= w_addr + 1'b1;
              state  <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Scoreboarded bench for mac_layer_sequencer: a behavioural ROM, an arithmetic layer model
// feeding expectation queues, and a negedge monitor that checks data, addresses and timing.
module tb_mac_layer_sequencer;

  localparam int N_IN  = 10;
  localparam int N_OUT = 10;
  localparam int DW    = 24;
  localparam int AW    = 8;
  localparam int STRIDE = N_IN + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [N_IN*DW-1:0] act_in = '0;
  logic               busy;
  logic               w_rd;
  logic [AW-1:0]      w_addr;
  logic [DW-1:0]      w_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [7:0]         out_idx;
  logic [7:0]         out_data;
  logic               done;

  mac_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .act_in(act_in), .busy(busy),
    .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom [256];
  always @(posedge clk)
    if (w_rd) w_data <= rom[w_addr];

  logic [15:0] exp_q [$];
  int          addr_q [$];
  int compared = 0;
  int mismatched = 0;
  int launch_count = 0;
  int abort_count = 0;
  int done_count = 0;
  int ready_mode = 0;

  task automatic checkOutput(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Layer model: plain signed sums truncated to DW, then the clamped ReLU by division
  task automatic applyStimulus(input logic [N_IN*DW-1:0] acts);
    for (int o = 0; o < N_OUT; o++) begin
      longint s = 0;
      logic signed [DW-1:0] a;
      logic [7:0] r;
      for (int j = 0; j < N_IN; j++)
        s += longint'($signed(acts[j*DW +: DW])) * longint'($signed(rom[o*STRIDE + j]));
      s += longint'($signed(rom[o*STRIDE + N_IN]));
      a = s[DW-1:0];
      if (a < 0) r = 8'd0;
      else if (a > 4096) r = 8'd255;
      else r = 8'(a / 32);
      exp_q.push_back({8'(o), r});
      for (int k = 0; k <= N_IN; k++)
        addr_q.push_back(o*STRIDE + k);
    end
    @(negedge clk);
    start  = 1'b1;
    act_in = acts;
    @(posedge clk);
    #1;
    start = 1'b0;
    launch_count++;
  endtask

  task automatic waitDone();
    int t = 0;
    int dc = done_count;
    while (done_count == dc && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (done_count == dc) begin
      $display("[TB] FAIL timeout: no done after %0d cycles", t);
      $fatal(1, "[TB] aborting");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic fillRom(input int w, input int b);
    for (int o = 0; o < N_OUT; o++) begin
      for (int j = 0; j < N_IN; j++) rom[o*STRIDE + j] = DW'(w);
      rom[o*STRIDE + N_IN] = DW'(b);
    end
  endtask

  task automatic fillRomRandom();
    for (int o = 0; o < N_OUT; o++) begin
      for (int j = 0; j < N_IN; j++) rom[o*STRIDE + j] = DW'(int'($urandom_range(16)) - 8);
      rom[o*STRIDE + N_IN] = DW'(int'($urandom_range(1000)) - 500);
    end
  endtask

  function automatic logic [N_IN*DW-1:0] allActs(input int v);
    logic [N_IN*DW-1:0] p;
    for (int j = 0; j < N_IN; j++) p[j*DW +: DW] = DW'(v);
    return p;
  endfunction

  function automatic logic [N_IN*DW-1:0] randActs();
    logic [N_IN*DW-1:0] p;
    for (int j = 0; j < N_IN; j++) p[j*DW +: DW] = DW'(int'($urandom_range(400)) - 200);
    return p;
  endfunction

  // Consumer: always ready, randomly ready, or a five-cycle stall on neuron 3
  int stall = 0;
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) begin
      out_ready = 1'b1;
      stall = 0;
    end else if (ready_mode == 1) begin
      out_ready = ($urandom_range(3) != 0);
      stall = 0;
    end else if (out_valid && out_idx == 8'd3 && stall < 5) begin
      out_ready = 1'b0;
      stall++;
    end else begin
      out_ready = 1'b1;
    end
  end

  int  launch_seen = 0;
  int  abort_seen = 0;
  bit  active = 1'b0;
  bit  vis = 1'b0;
  int  rel = 0;
  int  last_hs = 0;
  int  stalls = 0;
  logic [15:0] held;

  always @(negedge clk) begin
    if (abort_count != abort_seen) begin
      abort_seen = abort_count;
      active = 1'b0;
      exp_q.delete();
      addr_q.delete();
      checkOutput("reset_values", int'({busy, w_rd, w_addr, out_valid, out_idx, out_data, done}), 0);
    end else begin
      if (launch_count != launch_seen) begin
        launch_seen = launch_count;
        active = 1'b1;
        rel = 1;
        last_hs = 0;
        stalls = 0;
        vis = 1'b0;
      end else if (active) begin
        rel++;
      end
      if (!active) begin
        checkOutput("idle_quiet", int'({busy, w_rd, out_valid, done}), 0);
      end else begin
        if (rel == 1) checkOutput("start_busy_rd", int'({busy, w_rd}), 3);
        if (w_rd) begin
          if (addr_q.size() == 0) checkOutput("addr_extra", int'(w_addr), -1);
          else checkOutput("w_addr", int'(w_addr), addr_q.pop_front());
        end
        if (out_valid) begin
          checkOutput("rd_in_emit", int'(w_rd), 0);
          if (!vis) begin
            vis = 1'b1;
            held = {out_idx, out_data};
            checkOutput("valid_time", rel, last_hs + N_IN + 3);
          end else begin
            checkOutput("hold_stable", int'({out_idx, out_data}), int'(held));
          end
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              checkOutput("out_extra", int'(out_idx), -1);
            end else begin
              logic [15:0] e;
              e = exp_q.pop_front();
              checkOutput("out_idx", int'(out_idx), int'(e[15:8]));
              checkOutput("out_data", int'(out_data), int'(e[7:0]));
            end
            last_hs = rel;
            vis = 1'b0;
          end else begin
            stalls++;
          end
        end
        if (done) begin
          checkOutput("done_time", rel, N_OUT*(N_IN + 3) + 1 + stalls);
          checkOutput("done_busy", int'(busy), 1);
          checkOutput("left_over", exp_q.size() + addr_q.size(), 0);
          active = 1'b0;
          done_count++;
        end
      end
    end
  end

  initial begin
    logic [N_IN*DW-1:0] p;
    fillRom(0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    abort_count++;
    repeat (2) @(negedge clk);

    $display("[TB] nominal");
    fillRom(1, 0);
    applyStimulus(allActs(32));
    waitDone();

    $display("[TB] saturation and negative");
    fillRom(10, 6);
    applyStimulus(allActs(1000));
    waitDone();
    fillRom(-1, 0);
    applyStimulus(allActs(32));
    waitDone();

    $display("[TB] clamp boundary");
    fillRomRandom();
    for (int o = 0; o < 3; o++) rom[o*STRIDE] = DW'(1);
    rom[0*STRIDE + N_IN] = DW'(0);
    rom[1*STRIDE + N_IN] = DW'(1);
    rom[2*STRIDE + N_IN] = DW'(-1);
    p = '0;
    p[DW-1:0] = DW'(4096);
    applyStimulus(p);
    waitDone();

    $display("[TB] backpressure");
    fillRom(1, 0);
    ready_mode = 2;
    applyStimulus(allActs(32));
    waitDone();
    ready_mode = 0;

    $display("[TB] reset mid-run");
    fillRomRandom();
    applyStimulus(randActs());
    repeat (40) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    abort_count++;
    repeat (4) @(negedge clk);
    applyStimulus(randActs());
    waitDone();

    $display("[TB] start while busy");
    applyStimulus(randActs());
    repeat (20) @(negedge clk);
    start  = 1'b1;
    act_in = randActs();
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone();

    $display("[TB] random runs");
    ready_mode = 1;
    for (int r = 0; r < 4; r++) begin
      fillRomRandom();
      applyStimulus(randActs());
      waitDone();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
